// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : ctrl_pkg                                                    |
// | Description: Shared types and encodings for multicycle_control_unit.     |
// |              Macro DP_EXT_OPS_EN adds the EOR and CMP data-processing    |
// |              commands to the decoder.                                    |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_ORR = 3'b011;
    localparam logic [2:0] C_ALU_EOR = 3'b100;

    localparam logic [1:0] C_RES_ALUOUT    = 2'b00;
    localparam logic [1:0] C_RES_DATA      = 2'b01;
    localparam logic [1:0] C_RES_ALURESULT = 2'b10;

    localparam logic [1:0] C_SRCA_REG  = 2'b00;
    localparam logic [1:0] C_SRCA_PC   = 2'b01;
    localparam logic [1:0] C_SRCB_REG  = 2'b00;
    localparam logic [1:0] C_SRCB_IMM  = 2'b01;
    localparam logic [1:0] C_SRCB_FOUR = 2'b10;

    localparam logic [1:0] C_IMM_DP  = 2'b00;
    localparam logic [1:0] C_IMM_MEM = 2'b01;
    localparam logic [1:0] C_IMM_BR  = 2'b10;

    localparam logic [1:0] C_REGSRC_BR  = 2'b01;
    localparam logic [1:0] C_REGSRC_STR = 2'b10;

    localparam logic [3:0] C_CMD_AND = 4'b0000;
    localparam logic [3:0] C_CMD_EOR = 4'b0001;
    localparam logic [3:0] C_CMD_SUB = 4'b0010;
    localparam logic [3:0] C_CMD_ADD = 4'b0100;
    localparam logic [3:0] C_CMD_CMP = 4'b1010;
    localparam logic [3:0] C_CMD_ORR = 4'b1100;

    localparam logic [3:0] C_COND_EQ = 4'b0000;
    localparam logic [3:0] C_COND_NE = 4'b0001;
    localparam logic [3:0] C_COND_CS = 4'b0010;
    localparam logic [3:0] C_COND_CC = 4'b0011;
    localparam logic [3:0] C_COND_MI = 4'b0100;
    localparam logic [3:0] C_COND_PL = 4'b0101;
    localparam logic [3:0] C_COND_VS = 4'b0110;
    localparam logic [3:0] C_COND_VC = 4'b0111;
    localparam logic [3:0] C_COND_HI = 4'b1000;
    localparam logic [3:0] C_COND_LS = 4'b1001;
    localparam logic [3:0] C_COND_GE = 4'b1010;
    localparam logic [3:0] C_COND_LT = 4'b1011;
    localparam logic [3:0] C_COND_GT = 4'b1100;
    localparam logic [3:0] C_COND_LE = 4'b1101;
    localparam logic [3:0] C_COND_AL = 4'b1110;

    // wb_en clear means the result never reaches the register file or PC.
    typedef struct packed {
        logic       supported;
        logic [2:0] alu_ctrl;
        logic       wr_cv;
        logic       wb_en;
    } dp_dec_t;

    function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
        dp_dec_t d;
        d = '{supported: 1'b0, alu_ctrl: C_ALU_ADD, wr_cv: 1'b0, wb_en: 1'b0};
        case (cmd)
            C_CMD_ADD: d = '{1'b1, C_ALU_ADD, 1'b1, 1'b1};
            C_CMD_SUB: d = '{1'b1, C_ALU_SUB, 1'b1, 1'b1};
            C_CMD_AND: d = '{1'b1, C_ALU_AND, 1'b0, 1'b1};
            C_CMD_ORR: d = '{1'b1, C_ALU_ORR, 1'b0, 1'b1};
`ifdef DP_EXT_OPS_EN
            C_CMD_EOR: d = '{1'b1, C_ALU_EOR, 1'b0, 1'b1};
            C_CMD_CMP: d = '{1'b1, C_ALU_SUB, 1'b1, 1'b0};
`endif
            default: ;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface  : multicycle_control_unit_if                                  |
// | Description: Instruction fields, ALU flags and datapath controls.        |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
interface multicycle_control_unit_if #(
    parameter int ALUCTRL_W = 3
);
    logic [3:0]           Cond;
    logic [1:0]           Op;
    logic [5:0]           Funct;
    logic [3:0]           Rd;
    logic [3:0]           ALUFlags;
    logic                 PCWrite;
    logic                 MemWrite;
    logic                 RegWrite;
    logic                 IRWrite;
    logic                 AdrSrc;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic [3:0]           Flags;
    logic [3:0]           State;

    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
        output ALUControl, Flags, State
    );

    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
        input  ALUControl, Flags, State
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit_cond_check.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : cond_check                                                  |
// | Description: NZCV flag register and ARM condition evaluation into CondEx.|
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module cond_check
    import ctrl_pkg::*;
#(
    parameter int COND_EN = 1
) (
    input  wire       clk,
    input  wire       rst_n,
    input  wire [3:0] i_cond,
    input  wire [3:0] i_alu_flags,
    input  wire       i_condex_load,
    input  wire       i_wr_nz,
    input  wire       i_wr_cv,
    output logic [3:0] o_flags,
    output logic       o_condex
);

    logic [3:0] r_flags_q;
    logic [3:0] w_flags_d;
    logic       r_condex_q;
    logic       w_condex_d;
    logic       w_cond_eval;
    logic       w_cond_true;
    logic       w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags_q;

    always_comb begin
        w_cond_eval = 1'b0;
        case (i_cond)
            C_COND_EQ: w_cond_eval = w_z;
            C_COND_NE: w_cond_eval = ~w_z;
            C_COND_CS: w_cond_eval = w_c;
            C_COND_CC: w_cond_eval = ~w_c;
            C_COND_MI: w_cond_eval = w_n;
            C_COND_PL: w_cond_eval = ~w_n;
            C_COND_VS: w_cond_eval = w_v;
            C_COND_VC: w_cond_eval = ~w_v;
            C_COND_HI: w_cond_eval = w_c & ~w_z;
            C_COND_LS: w_cond_eval = ~w_c | w_z;
            C_COND_GE: w_cond_eval = (w_n == w_v);
            C_COND_LT: w_cond_eval = (w_n != w_v);
            C_COND_GT: w_cond_eval = ~w_z & (w_n == w_v);
            C_COND_LE: w_cond_eval = w_z | (w_n != w_v);
            C_COND_AL: w_cond_eval = 1'b1;
            default:   w_cond_eval = 1'b0;
        endcase
    end

    generate
        if (COND_EN != 0) begin : g_cond_on
            assign w_cond_true = w_cond_eval;
        end else begin : g_cond_off
            assign w_cond_true = 1'b1;
        end
    endgenerate

    always_comb begin
        w_flags_d = r_flags_q;
        if (i_wr_nz) w_flags_d[3:2] = i_alu_flags[3:2];
        if (i_wr_cv) w_flags_d[1:0] = i_alu_flags[1:0];
        w_condex_d = i_condex_load ? w_cond_true : r_condex_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags_q  <= 4'b0000;
            r_condex_q <= 1'b0;
        end else begin
            r_flags_q  <= w_flags_d;
            r_condex_q <= w_condex_d;
        end
    end

    assign o_flags  = r_flags_q;
    assign o_condex = r_condex_q;

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : multicycle_control_unit                                     |
// | Description: Multicycle ARM-subset control FSM. Macro DP_EXT_OPS_EN      |
// |              enables EOR/CMP decode (see ctrl_pkg::dp_decode).           |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int COND_EN   = 1
) (
    input  wire                       clk,
    input  wire                       rst_n,
    multicycle_control_unit_if.master mcu
);

    state_t     r_state_q;
    state_t     w_state_d;
    dp_dec_t    w_dp;
    logic       w_condex;
    logic       w_rd_is_pc;
    logic       w_condex_load;
    logic       w_flag_wr_nz;
    logic       w_flag_wr_cv;
    logic       w_pc_write, w_mem_write, w_reg_write, w_ir_write, w_adr_src;
    logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b, w_imm_src, w_reg_src;
    logic [2:0] w_alu_ctrl;

    assign w_dp       = dp_decode(mcu.Funct[4:1]);
    assign w_rd_is_pc = (mcu.Rd == 4'hF);

    cond_check #(
        .COND_EN(COND_EN)
    ) u_cond_check (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cond       (mcu.Cond),
        .i_alu_flags  (mcu.ALUFlags),
        .i_condex_load(w_condex_load),
        .i_wr_nz      (w_flag_wr_nz),
        .i_wr_cv      (w_flag_wr_cv),
        .o_flags      (mcu.Flags),
        .o_condex     (w_condex)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state_q <= S_FETCH;
        else        r_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = S_FETCH;
        case (r_state_q)
            S_FETCH:  w_state_d = S_DECODE;
            S_DECODE: begin
                case (mcu.Op)
                    2'b01:   w_state_d = S_MEMADR;
                    2'b00:   w_state_d = mcu.Funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   w_state_d = S_BRANCH;
                    default: w_state_d = S_FETCH;
                endcase
            end
            S_MEMADR: w_state_d = mcu.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:  w_state_d = S_ALUWB;
            default:  w_state_d = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_adr_src     = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_imm_src     = 2'b00;
        w_reg_src     = 2'b00;
        w_alu_ctrl    = C_ALU_ADD;
        w_condex_load = 1'b0;
        w_flag_wr_nz  = 1'b0;
        w_flag_wr_cv  = 1'b0;
        case (r_state_q)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_pc_write   = 1'b1;
                w_alu_src_a  = C_SRCA_PC;
                w_alu_src_b  = C_SRCB_FOUR;
                w_result_src = C_RES_ALURESULT;
            end
            S_DECODE: begin
                w_alu_src_a   = C_SRCA_PC;
                w_alu_src_b   = C_SRCB_FOUR;
                w_result_src  = C_RES_ALURESULT;
                w_condex_load = 1'b1;
            end
            S_MEMADR: begin
                w_alu_src_a = C_SRCA_REG;
                w_alu_src_b = C_SRCB_IMM;
                w_imm_src   = C_IMM_MEM;
            end
            S_MEMRD: w_adr_src = 1'b1;
            S_MEMWB: begin
                w_result_src = C_RES_DATA;
                w_reg_write  = w_condex;
            end
            S_MEMWR: begin
                w_adr_src   = 1'b1;
                w_reg_src   = C_REGSRC_STR;
                w_mem_write = w_condex;
            end
            S_EXECR, S_EXECI: begin
                w_alu_src_a  = C_SRCA_REG;
                w_alu_src_b  = (r_state_q == S_EXECI) ? C_SRCB_IMM : C_SRCB_REG;
                w_imm_src    = C_IMM_DP;
                w_alu_ctrl   = w_dp.alu_ctrl;
                // CondEx was captured in DECODE, so this update cannot alter ALUWB.
                w_flag_wr_nz = mcu.Funct[0] & w_condex & w_dp.supported;
                w_flag_wr_cv = mcu.Funct[0] & w_condex & w_dp.supported & w_dp.wr_cv;
            end
            S_ALUWB: begin
                w_result_src = C_RES_ALUOUT;
                w_reg_write  = w_condex & w_dp.wb_en & ~w_rd_is_pc;
                w_pc_write   = w_condex & w_dp.wb_en & w_rd_is_pc;
            end
            S_BRANCH: begin
                w_alu_src_a  = C_SRCA_REG;
                w_alu_src_b  = C_SRCB_IMM;
                w_imm_src    = C_IMM_BR;
                w_reg_src    = C_REGSRC_BR;
                w_result_src = C_RES_ALURESULT;
                w_pc_write   = w_condex;
            end
            default: ;
        endcase
    end

    // Strobes are gated directly by rst_n so nothing is written while reset is held.
    assign mcu.PCWrite    = w_pc_write  & rst_n;
    assign mcu.MemWrite   = w_mem_write & rst_n;
    assign mcu.RegWrite   = w_reg_write & rst_n;
    assign mcu.IRWrite    = w_ir_write  & rst_n;
    assign mcu.AdrSrc     = w_adr_src;
    assign mcu.ResultSrc  = w_result_src;
    assign mcu.ALUSrcA    = w_alu_src_a;
    assign mcu.ALUSrcB    = w_alu_src_b;
    assign mcu.ImmSrc     = w_imm_src;
    assign mcu.RegSrc     = w_reg_src;
    assign mcu.ALUControl = ALUCTRL_W'(w_alu_ctrl);
    assign mcu.State      = r_state_q;

endmodule
`default_nettype wire
